// File: rtl/bird_motion_seq_if.sv
// bird_motion_seq_if
// Pixel plot port between the bird sequencer and the VGA framebuffer.
// A pixel (plot_x, plot_y, plot_colour) is held by the master until an edge
// where plot_valid && plot_ready; one pixel per cycle is possible.
//   plot_x      [7:0]  pixel column        (master -> slave)
//   plot_y      [6:0]  pixel row           (master -> slave)
//   plot_colour [2:0]  pixel colour        (master -> slave)
//   plot_valid         pixel request       (master -> slave)
//   plot_ready         pixel accepted      (slave -> master)
interface bird_motion_seq_if;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot_valid;
    logic       plot_ready;

    modport master (output plot_x, plot_y, plot_colour, plot_valid, input plot_ready);
    modport slave  (input plot_x, plot_y, plot_colour, plot_valid, output plot_ready);
endinterface

// File: rtl/bird_motion_seq.sv
// bird_motion_seq
// Per-frame bird sprite sequencer: on a frame tick it erases the sprite at the
// old row, applies gravity/flap physics for one cycle, then redraws the sprite.
// Also owns the sticky ground-collision flag (touched).
//   clk, resetn      clock, synchronous active-low reset
//   i_frame_tick     one-cycle pulse per video frame
//   i_game_run       high during play
//   i_start          pulse: re-centre bird, clear touched
//   i_flap           pulse: flap request
//   plot             framebuffer pixel port (master side)
//   o_bird_y         current top row of the bird
//   o_touched        sticky ground collision
//   o_busy           high while a frame is being processed
//   o_overrun_cnt    ticks dropped while busy (only with BIRD_OVERRUN_CNT_EN,
//                    otherwise tied to 0)
//
// state  | meaning
// IDLE   | waiting for a frame tick or start
// ERASE  | plotting sprite in colour 0 at the old row
// UPDATE | one-cycle physics step
// DRAW   | plotting sprite in BIRD_COLOUR at the new row
module bird_motion_seq #(
    parameter int         SCREEN_H    = 120,
    parameter int         BIRD_X      = 40,
    parameter int         BIRD_W      = 4,
    parameter int         BIRD_H      = 4,
    parameter int         START_Y     = 56,
    parameter int         GRAVITY     = 1,
    parameter int         VMAX        = 4,
    parameter int         FLAP_VEL    = -6,
    parameter logic [2:0] BIRD_COLOUR = 3'b110
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_frame_tick,
    input  logic                     i_game_run,
    input  logic                     i_start,
    input  logic                     i_flap,
    bird_motion_seq_if.master        plot,
    output logic [6:0]               o_bird_y,
    output logic                     o_touched,
    output logic                     o_busy,
    output logic [7:0]               o_overrun_cnt
);
    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    localparam logic signed [8:0] C_GRAV  = 9'(GRAVITY);
    localparam logic signed [8:0] C_VMAX  = 9'(VMAX);
    localparam logic signed [8:0] C_FLAP  = 9'(FLAP_VEL);
    localparam logic signed [8:0] C_YMAX  = 9'(SCREEN_H - BIRD_H);
    localparam logic [7:0]        C_DXL   = 8'(BIRD_W - 1);
    localparam logic [6:0]        C_DYL   = 7'(BIRD_H - 1);

    state_t            r_state, w_state_n;
    logic [7:0]        r_dx, w_dx_n;
    logic [6:0]        r_dy, w_dy_n;
    logic [7:0]        r_px, w_px_n;
    logic [6:0]        r_py, w_py_n;
    logic [2:0]        r_col, w_col_n;
    logic              r_valid, w_valid_n;
    logic [6:0]        r_bird_y, w_bird_y_n;
    logic signed [8:0] r_vel, w_vel_n;
    logic              r_touched, w_touched_n;
    logic              r_start_p, w_start_p_n;
    logic              r_flap_p, w_flap_p_n;

    logic signed [8:0] w_v_inc, w_v_upd, w_y_sum;
    logic              w_last;

    always_comb begin
        w_v_inc = r_vel + C_GRAV;
        w_v_upd = r_flap_p ? C_FLAP : ((w_v_inc > C_VMAX) ? C_VMAX : w_v_inc);
        w_y_sum = $signed({2'b00, r_bird_y}) + w_v_upd;
    end

    assign w_last = (r_dx == C_DXL) && (r_dy == C_DYL);

    always_comb begin
        w_state_n   = r_state;
        w_dx_n      = r_dx;
        w_dy_n      = r_dy;
        w_px_n      = r_px;
        w_py_n      = r_py;
        w_col_n     = r_col;
        w_valid_n   = r_valid;
        w_bird_y_n  = r_bird_y;
        w_vel_n     = r_vel;
        w_touched_n = r_touched;
        w_start_p_n = r_start_p | i_start;
        w_flap_p_n  = r_flap_p | i_flap;
        case (r_state)
            IDLE: begin
                if ((i_frame_tick && i_game_run && !r_touched) || r_start_p || i_start) begin
                    w_state_n = ERASE;
                    w_valid_n = 1'b1;
                    w_dx_n    = '0;
                    w_dy_n    = '0;
                    w_px_n    = 8'(BIRD_X);
                    w_py_n    = r_bird_y;
                    w_col_n   = 3'b000;
                end
            end
            ERASE, DRAW: begin
                if (r_valid && plot.plot_ready) begin
                    if (w_last) begin
                        w_state_n = (r_state == ERASE) ? UPDATE : IDLE;
                        w_valid_n = 1'b0;
                    end else begin
                        if (r_dx == C_DXL) begin
                            w_dx_n = '0;
                            w_dy_n = r_dy + 7'd1;
                        end else begin
                            w_dx_n = r_dx + 8'd1;
                        end
                        w_px_n = 8'(BIRD_X) + w_dx_n;
                        w_py_n = r_bird_y + w_dy_n;
                    end
                end
            end
            UPDATE: begin
                // Pulses landing in this cycle are kept for the next frame.
                w_start_p_n = i_start;
                w_flap_p_n  = i_flap;
                if (r_start_p) begin
                    w_bird_y_n  = 7'(START_Y);
                    w_vel_n     = '0;
                    w_touched_n = 1'b0;
                end else begin
                    w_vel_n = w_v_upd;
                    if (w_y_sum < 0) begin
                        w_bird_y_n = '0;
                        w_vel_n    = '0;
                    end else if (w_y_sum > C_YMAX) begin
                        w_bird_y_n  = C_YMAX[6:0];
                        w_touched_n = 1'b1;
                    end else begin
                        w_bird_y_n = w_y_sum[6:0];
                    end
                end
                w_state_n = DRAW;
                w_valid_n = 1'b1;
                w_dx_n    = '0;
                w_dy_n    = '0;
                w_px_n    = 8'(BIRD_X);
                w_py_n    = w_bird_y_n;
                w_col_n   = BIRD_COLOUR;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_dx      <= '0;
            r_dy      <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_col     <= '0;
            r_valid   <= 1'b0;
            r_bird_y  <= 7'(START_Y);
            r_vel     <= '0;
            r_touched <= 1'b0;
            r_start_p <= 1'b0;
            r_flap_p  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_dx      <= w_dx_n;
            r_dy      <= w_dy_n;
            r_px      <= w_px_n;
            r_py      <= w_py_n;
            r_col     <= w_col_n;
            r_valid   <= w_valid_n;
            r_bird_y  <= w_bird_y_n;
            r_vel     <= w_vel_n;
            r_touched <= w_touched_n;
            r_start_p <= w_start_p_n;
            r_flap_p  <= w_flap_p_n;
        end
    end

    assign plot.plot_x      = r_px;
    assign plot.plot_y      = r_py;
    assign plot.plot_colour = r_col;
    assign plot.plot_valid  = r_valid;
    assign o_bird_y         = r_bird_y;
    assign o_touched        = r_touched;
    assign o_busy           = (r_state != IDLE);

`ifdef BIRD_OVERRUN_CNT_EN
    logic [7:0] r_overrun;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_overrun <= '0;
        end else if (i_frame_tick && o_busy && i_game_run && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign o_overrun_cnt = r_overrun;
`else
    assign o_overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_bird_motion_seq.sv
module tb_bird_motion_seq;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       i_frame_tick = 1'b0;
    logic       i_game_run = 1'b0;
    logic       i_start = 1'b0;
    logic       i_flap = 1'b0;
    logic [6:0] o_bird_y;
    logic       o_touched;
    logic       o_busy;
    logic [7:0] o_overrun_cnt;

    bird_motion_seq_if plot_if();

    bird_motion_seq dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_frame_tick  (i_frame_tick),
        .i_game_run    (i_game_run),
        .i_start       (i_start),
        .i_flap        (i_flap),
        .plot          (plot_if),
        .o_bird_y      (o_bird_y),
        .o_touched     (o_touched),
        .o_busy        (o_busy),
        .o_overrun_cnt (o_overrun_cnt)
    );

    always #5 clk = ~clk;

`ifdef BIRD_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model: bird physics in plain integers
    int m_y = 56;
    int m_v = 0;
    bit m_touched = 1'b0;
    bit m_start_p = 1'b0;
    bit m_flap_p = 1'b0;
    int m_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_physics();
        int yn;
        if (m_start_p) begin
            m_y = 56;
            m_v = 0;
            m_touched = 1'b0;
        end else begin
            if (m_flap_p) m_v = -6;
            else m_v = (m_v + 1 > 4) ? 4 : m_v + 1;
            yn = m_y + m_v;
            if (yn < 0) begin
                m_y = 0;
                m_v = 0;
            end else if (yn > 116) begin
                m_y = 116;
                m_touched = 1'b1;
            end else begin
                m_y = yn;
            end
        end
        m_start_p = 1'b0;
        m_flap_p = 1'b0;
    endfunction

    task automatic pulse_flap();
        i_flap = 1'b1;
        step();
        i_flap = 1'b0;
        m_flap_p = 1'b1;
    endtask

    task automatic tick_ignored(input string tag);
        i_frame_tick = 1'b1;
        step();
        i_frame_tick = 1'b0;
        repeat (2) begin
            chk({tag, "_busy"}, o_busy, 0);
            chk({tag, "_valid"}, plot_if.plot_valid, 0);
            step();
        end
    endtask

    // One full frame: trigger, handshake all pixels, compare against the model.
    task automatic run_frame(input bit use_start, input int rmode, input bit flap_mid,
                             input int extra_ticks);
        logic [17:0] acc[$];
        logic [17:0] exp_px;
        int old_y, cyc, busy_cnt, ticks_sent, idx, ex, ey, ec;
        bit rdy, flapped;
        old_y = m_y;
        if (use_start) begin
            i_start = 1'b1;
            m_start_p = 1'b1;
        end else begin
            i_frame_tick = 1'b1;
        end
        step();
        i_start = 1'b0;
        i_frame_tick = 1'b0;
        model_physics();
        cyc = 0; busy_cnt = 0; ticks_sent = 0; flapped = 1'b0;
        while (o_busy && cyc < 400) begin
            busy_cnt++;
            cyc++;
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            plot_if.plot_ready = rdy;
            i_flap = 1'b0;
            i_frame_tick = 1'b0;
            if (flap_mid && !flapped && acc.size() == 20) begin
                i_flap = 1'b1;
                flapped = 1'b1;
            end
            if (ticks_sent < extra_ticks && cyc % 2 == 0) begin
                i_frame_tick = 1'b1;
                ticks_sent++;
            end
            if (plot_if.plot_valid && rdy)
                acc.push_back({plot_if.plot_x, plot_if.plot_y, plot_if.plot_colour});
            step();
        end
        i_flap = 1'b0;
        i_frame_tick = 1'b0;
        plot_if.plot_ready = 1'b0;
        if (flapped) m_flap_p = 1'b1;
        if (OVR_EN) m_ovr = (m_ovr + ticks_sent > 255) ? 255 : m_ovr + ticks_sent;
        chk("frame_done", o_busy, 0);
        chk("accept_count", acc.size(), 32);
        if (rmode == 0) chk("busy_cycles", busy_cnt, 33);
        for (int k = 0; k < acc.size() && k < 32; k++) begin
            idx = k % 16;
            ex = 40 + idx % 4;
            ey = ((k < 16) ? old_y : m_y) + idx / 4;
            ec = (k < 16) ? 0 : 6;
            exp_px = {8'(ex), 7'(ey), 3'(ec)};
            chk((k < 16) ? "erase_px" : "draw_px", acc[k], exp_px);
        end
        chk("bird_y", o_bird_y, m_y);
        chk("touched", o_touched, m_touched);
        chk("overrun", o_overrun_cnt, m_ovr);
    endtask

    initial begin
        int guard;
        plot_if.plot_ready = 1'b0;
        resetn = 1'b0;
        repeat (3) step();
        chk("rst_bird_y", o_bird_y, 56);
        chk("rst_touched", o_touched, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", plot_if.plot_valid, 0);
        chk("rst_x", plot_if.plot_x, 0);
        chk("rst_y", plot_if.plot_y, 0);
        chk("rst_colour", plot_if.plot_colour, 0);
        chk("rst_overrun", o_overrun_cnt, 0);
        resetn = 1'b1;
        step();

        // start while not running: full erase/draw at the start row
        run_frame(1'b1, 0, 1'b0, 0);
        tick_ignored("tick_no_run");

        // free fall
        i_game_run = 1'b1;
        run_frame(1'b0, 0, 1'b0, 0);
        chk("fall_1", o_bird_y, 57);
        run_frame(1'b0, 0, 1'b0, 0);
        chk("fall_2", o_bird_y, 59);
        run_frame(1'b0, 0, 1'b1, 0);
        chk("fall_3", o_bird_y, 62);
        run_frame(1'b0, 0, 1'b0, 0);
        chk("flap_up", o_bird_y, 56);

        // fall to the ground with random ready
        guard = 0;
        while (!m_touched && guard < 60) begin
            run_frame(1'b0, 2, 1'b0, 0);
            guard++;
        end
        chk("ground_y", o_bird_y, 116);
        chk("ground_touched", o_touched, 1);
        tick_ignored("tick_touched");

        // restart with alternating ready
        run_frame(1'b1, 1, 1'b0, 0);
        chk("restart_y", o_bird_y, 56);
        chk("restart_touched", o_touched, 0);

        // keep flapping into the ceiling
        guard = 0;
        while (m_y != 0 && guard < 15) begin
            pulse_flap();
            run_frame(1'b0, 2, 1'b0, 0);
            guard++;
        end
        chk("ceiling_y", o_bird_y, 0);
        chk("ceiling_touched", o_touched, 0);

        // random play
        for (int n = 0; n < 20; n++) begin
            if (m_touched) begin
                run_frame(1'b1, int'($urandom_range(0, 2)), 1'b0, 0);
            end else begin
                if ($urandom_range(0, 1) == 1) pulse_flap();
                run_frame(1'b0, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, 0);
            end
        end

        // ticks arriving during a busy frame are dropped (and counted if enabled)
        run_frame(1'b1, 0, 1'b0, 0);
        run_frame(1'b0, 0, 1'b0, 3);
        step();
        chk("no_retrigger", o_busy, 0);

        // reset in the middle of ERASE
        i_frame_tick = 1'b1;
        step();
        i_frame_tick = 1'b0;
        step();
        step();
        chk("mid_erase_valid", plot_if.plot_valid, 1);
        resetn = 1'b0;
        step();
        chk("midrst_valid", plot_if.plot_valid, 0);
        chk("midrst_bird_y", o_bird_y, 56);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_overrun", o_overrun_cnt, 0);
        resetn = 1'b1;
        m_y = 56; m_v = 0; m_touched = 1'b0; m_start_p = 1'b0; m_flap_p = 1'b0; m_ovr = 0;
        step();
        run_frame(1'b1, 2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bird_motion_seq.md
Name: bird_motion_seq

Overview:
Per-frame sequencer for the bird sprite. It sits between the bird game-state controller (game_run, flap) and the VGA framebuffer plot port. On each frame tick it erases the bird at its old position, applies gravity/flap physics, and redraws it. It also produces the touched signal that the game-state controller consumes.

Parameters:
SCREEN_H, 120, screen height in pixels (bird_y range 0..SCREEN_H-BIRD_H)
BIRD_X, 40, fixed left column of sprite
BIRD_W, 4, sprite width
BIRD_H, 4, sprite height
START_Y, 56, y loaded on reset/start
GRAVITY, 1, velocity increment per frame
VMAX, 4, max downward velocity
FLAP_VEL, -6, velocity loaded on flap (signed)
BIRD_COLOUR, 3'b110, draw colour; erase colour is 3'b000

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
frame_tick  in  1  one-cycle pulse per video frame
game_run  in  1  high while game is in raising/falling play
start  in  1  pulse: re-centre bird, clear touched
flap  in  1  pulse: flap request
plot_x  out  8  pixel x
plot_y  out  7  pixel y
plot_colour  out  3  pixel colour
plot_valid  out  1  pixel request
plot_ready  in  1  framebuffer accepts pixel
bird_y  out  7  current top row of bird
touched  out  1  ground collision, sticky
busy  out  1  high while not IDLE
overrun_cnt  out  8  dropped-tick count (see Optional Feature)

Behaviour:
- Reset values: bird_y=START_Y, velocity=0, touched=0, plot_valid=0, plot_x/y/colour=0, busy=0, pending flags=0, state=IDLE.
- States: IDLE, ERASE, UPDATE, DRAW.
- Pending flags: start_p is set by start and flap_p by flap, in any state. Both are cleared in UPDATE. A pulse that coincides with UPDATE is held for the next frame.
- IDLE leaves on the edge where (frame_tick && game_run && !touched) || start_p || start. It goes to ERASE with plot_valid=1 and pixel 0 presented.
- Pixel walk is row-major (dx fastest): x=BIRD_X+dx, y=bird_y+dy.
- Handshake: x/y/colour/valid are held stable until an edge with plot_valid&&plot_ready. Back-to-back acceptance is allowed, one pixel per cycle.
- ERASE uses colour 0 at the old bird_y. After the last (BIRD_W*BIRD_H-th) pixel is accepted, go to UPDATE with plot_valid=0.
- UPDATE lasts one cycle:
  - If start_p: y=START_Y, v=0, touched=0.
  - Otherwise: v = flap_p ? FLAP_VEL : min(v+GRAVITY, VMAX); then y_n = y+v.
  - Physics arithmetic is signed 9-bit.
  - If y_n<0: y=0 and v=0 (ceiling clamp, no touch).
  - If y_n>SCREEN_H-BIRD_H: y=SCREEN_H-BIRD_H and touched=1.
  - Else y=y_n.
  - Next state is DRAW with pixel 0 valid.
- DRAW uses BIRD_COLOUR at the new bird_y. After the last pixel is accepted, go to IDLE.
- With plot_ready tied high: busy=1 for 2*W*H+1 = 33 cycles per frame.
- frame_tick while busy, while !game_run, or while touched: ignored and no state change.
- touched stays 1 until an UPDATE with start_p, or reset.
- Reset mid-frame: next edge returns to IDLE with all reset values, and plot_valid drops immediately. The framebuffer may hold a partial sprite; the next start redraws it.

Optional Feature:
BIRD_OVERRUN_CNT_EN
- Defined: overrun_cnt increments on every frame_tick that arrives while busy=1 and game_run=1. It saturates at 255 and clears only on reset.
- Undefined: overrun_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset, start pulse, plot_ready=1 -> 16 erase pixels colour 0 at y 56..59, then 16 draw pixels colour 6 at x 40..43, y 56..59; bird_y=56, busy high for 33 cycles.
- game_run=1, two ticks, no flap -> bird_y 57, then 59 (v=1,2).
- Flap pulse mid-DRAW, then next tick -> v=-6, bird_y 59->53; flap_p cleared.
- Repeated ticks with no flap until ground -> bird_y clamps at 116, touched=1. Further ticks give no plots; start -> bird_y=56, touched=0.
- plot_ready toggling 1010... -> every pixel is held until accepted, none skipped or duplicated, 16+16 accepted per frame. Ceiling: flap at bird_y=3 -> bird_y=0, touched=0.
- With BIRD_OVERRUN_CNT_EN: 3 ticks during one busy frame -> overrun_cnt=3; resetn low mid-ERASE -> plot_valid=0 and bird_y=56 next cycle.
